mm_tile_scheduler: RTL

//  Sequences the mm_main vector-matrix engine from a stream of MM instructions.

---
 rtl/mm_sched_pkg.sv | 53 +++++
 rtl/mm_tile_scheduler_if.sv | 22 ++
 rtl/mm_instr_decode.sv | 30 +++
 rtl/mm_tile_scheduler.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mm_sched_pkg.sv
// Shared types for the mm_main tile scheduler: FSM states, instruction field layout,
// decoded instruction struct and response codes.
package mm_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_RESP
    } state_t;

    localparam int W_LSB    = 0;
    localparam int W_W      = 13;
    localparam int IN_LSB   = 13;
    localparam int IN_W     = 11;
    localparam int OUT_LSB  = 24;
    localparam int OUT_W    = 11;
    localparam int BIAS_LSB = 35;
    localparam int BIAS_W   = 9;
    localparam int CI_LSB   = 44;
    localparam int CO_LSB   = 52;
    localparam int FEAT_W   = 8;
    localparam int N_LSB    = 60;
    localparam int N_W      = 16;
    localparam int R_BIT    = 76;
    localparam int A_BIT    = 77;
    localparam int B_BIT    = 78;
    localparam int USED_W   = 79;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_BAD     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef struct packed {
        logic [12:0] w;
        logic [10:0] in_addr;
        logic [10:0] out_addr;
        logic [8:0]  bias;
        logic [7:0]  ci;
        logic [7:0]  co;
        logic [15:0] n;
        logic        r;
        logic        a;
        logic        b;
    } instr_t;

    function automatic logic [15:0] tile_size(input logic [15:0] rem, input logic [15:0] max_n);
        return (rem > max_n) ? max_n : rem;
    endfunction

endpackage

// File: rtl/mm_tile_scheduler_if.sv
// Instruction-in / response-out handshake bundle between the fetch FIFO side and the scheduler.
interface mm_tile_scheduler_if #(
    parameter int INSTR_W = 96
) ();
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic               resp_valid;
    logic               resp_ready;
    logic [1:0]         resp_err;
    logic [15:0]        resp_tiles;

    modport master (
        output instr_valid, instr_data, resp_ready,
        input  instr_ready, resp_valid, resp_err, resp_tiles
    );

    modport slave (
        input  instr_valid, instr_data, resp_ready,
        output instr_ready, resp_valid, resp_err, resp_tiles
    );
endinterface

// File: rtl/mm_instr_decode.sv
// Splits an MM instruction word into its fields and flags words with a zero Ci, Co or N.
module mm_instr_decode
    import mm_sched_pkg::*;
#(
    parameter int INSTR_W = 96
) (
    input  logic [INSTR_W-1:0] instr_data,
    output instr_t             fields,
    output logic               ok
);
    // Upper bits are reserved and deliberately ignored.
    logic unused_reserved;
    assign unused_reserved = ^instr_data[INSTR_W-1:USED_W];

    always_comb begin
        fields          = '0;
        fields.w        = instr_data[W_LSB +: W_W];
        fields.in_addr  = instr_data[IN_LSB +: IN_W];
        fields.out_addr = instr_data[OUT_LSB +: OUT_W];
        fields.bias     = instr_data[BIAS_LSB +: BIAS_W];
        fields.ci       = instr_data[CI_LSB +: FEAT_W];
        fields.co       = instr_data[CO_LSB +: FEAT_W];
        fields.n        = instr_data[N_LSB +: N_W];
        fields.r        = instr_data[R_BIT];
        fields.a        = instr_data[A_BIT];
        fields.b        = instr_data[B_BIT];
    end

    assign ok = (fields.ci != '0) && (fields.co != '0) && (fields.n != '0);
endmodule

// File: rtl/mm_tile_scheduler.sv
// Turns MM instructions into a sequence of mm_main launches of at most MAX_TILE_N nodes,
// advancing input/output buffer addresses per tile, with a per-tile done watchdog.
//
// state | meaning
// IDLE  | ready for an instruction
// LOAD  | validate captured instruction, set up strides and first tile
// ISSUE | one-cycle start pulse to mm_main, arm watchdog
// WAIT  | wait for mm_done or watchdog expiry
// NEXT  | advance buffer addresses, size the next tile
// RESP  | present response until accepted
module mm_tile_scheduler
    import mm_sched_pkg::*;
#(
    parameter int INSTR_W     = 96,
    parameter int MAX_TILE_N  = 64,
    parameter int TIMEOUT_CYC = 1 << 20
) (
    input  logic                clk,
    input  logic                rstn,
    mm_tile_scheduler_if.slave  bus,
    output logic                mm_start_valid,
    output logic [12:0]         mm_weight_start_addr,
    output logic [10:0]         mm_input_start_addr,
    output logic [10:0]         mm_output_start_addr,
    output logic [8:0]          mm_bias_start_addr,
    output logic [7:0]          mm_input_addr_per_feature,
    output logic [7:0]          mm_output_addr_per_feature,
    output logic [15:0]         mm_number_of_node,
    output logic                mm_r,
    output logic                mm_a,
    output logic                mm_b,
    input  logic                mm_done,
    output logic                busy
);
    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [15:0]     MAX_N   = 16'(MAX_TILE_N);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

    state_t          state_q, state_d;
    instr_t          dec, cfg_q;
    logic            dec_ok, bad_q;
    logic [15:0]     remaining_q, tile_n_q, tiles_q;
    logic [10:0]     in_addr_q, out_addr_q, in_stride_q, out_stride_q;
    logic [1:0]      err_q;
    logic [WD_W-1:0] wd_q;

    mm_instr_decode #(.INSTR_W(INSTR_W)) u_decode (
        .instr_data (bus.instr_data),
        .fields     (dec),
        .ok         (dec_ok)
    );

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.instr_ready = rstn && (state_q == S_IDLE);
        bus.resp_valid  = (state_q == S_RESP);
        mm_start_valid  = (state_q == S_ISSUE);
        busy            = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  if (bus.instr_valid) state_d = S_LOAD;
            S_LOAD:  state_d = bad_q ? S_RESP : S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // A done arriving together with watchdog expiry still counts.
                if (mm_done)          state_d = (remaining_q == tile_n_q) ? S_RESP : S_NEXT;
                else if (wd_q == '0)  state_d = S_RESP;
            end
            S_NEXT:  state_d = S_ISSUE;
            S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cfg_q        <= '0;
            bad_q        <= 1'b0;
            remaining_q  <= '0;
            tile_n_q     <= '0;
            tiles_q      <= '0;
            in_addr_q    <= '0;
            out_addr_q   <= '0;
            in_stride_q  <= '0;
            out_stride_q <= '0;
            err_q        <= ERR_OK;
            wd_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        cfg_q   <= dec;
                        bad_q   <= !dec_ok;
                        tiles_q <= '0;
                        err_q   <= ERR_OK;
                    end
                end
                S_LOAD: begin
                    if (bad_q) begin
                        err_q <= ERR_BAD;
                    end else begin
                        remaining_q  <= cfg_q.n;
                        tile_n_q     <= tile_size(cfg_q.n, MAX_N);
                        in_addr_q    <= cfg_q.in_addr;
                        out_addr_q   <= cfg_q.out_addr;
                        in_stride_q  <= 11'(MAX_N * 16'(cfg_q.ci));
                        out_stride_q <= 11'(MAX_N * 16'(cfg_q.co));
                    end
                end
                S_ISSUE: wd_q <= WD_LOAD;
                S_WAIT: begin
                    if (mm_done) begin
                        remaining_q <= remaining_q - tile_n_q;
                        tiles_q     <= tiles_q + 16'd1;
                    end else if (wd_q == '0) begin
                        err_q <= ERR_TIMEOUT;
                    end else begin
                        wd_q <= wd_q - 1'b1;
                    end
                end
                S_NEXT: begin
                    in_addr_q  <= in_addr_q + in_stride_q;
                    out_addr_q <= out_addr_q + out_stride_q;
                    tile_n_q   <= tile_size(remaining_q, MAX_N);
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_err               = err_q;
    assign bus.resp_tiles             = tiles_q;
    assign mm_weight_start_addr       = cfg_q.w;
    assign mm_input_start_addr        = in_addr_q;
    assign mm_output_start_addr       = out_addr_q;
    assign mm_bias_start_addr         = cfg_q.bias;
    assign mm_input_addr_per_feature  = cfg_q.ci;
    assign mm_output_addr_per_feature = cfg_q.co;
    assign mm_number_of_node          = tile_n_q;
    assign mm_r                       = cfg_q.r;
    assign mm_a                       = cfg_q.a;
    assign mm_b                       = cfg_q.b;
endmodule
